// File: rtl/simd_shifter_pkg.sv
// Shared types for the SIMD shifter datapath and its issue stage.
// Lane-width helpers and the normalised command layout live here so both sides agree.
package simd_shifter_pkg;

    typedef logic [63:0] word_t;
    typedef enum logic [1:0] {B8 = 2'd0, B16 = 2'd1, B32 = 2'd2, B64 = 2'd3} mode_t;
    typedef enum logic [1:0] {SLL = 2'd0, SRL = 2'd1, SRA = 2'd2} op_t;
    typedef logic [5:0] shift_t;
    typedef shift_t [7:0] shift_vec_t;

    // The tag is appended by the issue stage so its width can follow TAG_W.
    typedef struct packed {
        word_t      data;
        mode_t      mode;
        op_t        op;
        shift_vec_t shift;
    } cmd_t;

    function automatic int unsigned lane_bits(mode_t m);
        return 32'd8 << m;
    endfunction

    function automatic shift_t lane_mask(mode_t m);
        case (m)
            B8:      return 6'h07;
            B16:     return 6'h0F;
            B32:     return 6'h1F;
            default: return 6'h3F;
        endcase
    endfunction

    function automatic shift_vec_t normalise_shift(shift_vec_t s, logic bcast, mode_t m);
        shift_vec_t r;
        for (int i = 0; i < 8; i++) begin
            r[i] = (bcast ? s[0] : s[i]) & lane_mask(m);
        end
        return r;
    endfunction

endpackage

// File: rtl/simd_shift_cmd_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; head is read combinationally.
// Full/empty come from the registered occupancy; the caller never pushes when full.
module simd_shift_cmd_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

endmodule

// File: rtl/simd_shifter.sv
// Combinational SIMD shifter: lane i of the selected width uses shift[i].
// Amounts are reduced modulo the lane width; SRA replicates each lane's own sign bit.
module simd_shifter
    import simd_shifter_pkg::*;
(
    input  word_t      data,
    input  mode_t      mode,
    input  op_t        op,
    input  shift_vec_t shift,
    output word_t      result
);

    function automatic word_t lane_op(word_t v, int unsigned w, shift_t s, op_t o);
        word_t  m;
        word_t  x;
        word_t  sx;
        word_t  r;
        shift_t sa;
        // For w == 64 the shift yields zero and the subtraction wraps to all ones.
        m  = (64'd1 << w) - 64'd1;
        x  = v & m;
        sx = ((x & (m ^ (m >> 1))) != '0) ? (x | ~m) : x;
        sa = s & shift_t'(w - 1);
        case (o)
            SLL:     r = x << sa;
            SRL:     r = x >> sa;
            SRA:     r = word_t'($signed(sx) >>> sa);
            default: r = x;
        endcase
        return r & m;
    endfunction

    always_comb begin
        int unsigned w;
        w      = lane_bits(mode);
        result = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 64 / w) begin
                result = result | (lane_op(data >> (i * w), w, shift[i], op) << (i * w));
            end
        end
    end

endmodule

// File: rtl/simd_shift_issue.sv
// Issue stage: buffers normalised shift commands, runs the FIFO head through the
// shifter and registers the result into a back-pressurable output stage.
module simd_shift_issue
    import simd_shifter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  word_t                  in_data,
    input  mode_t                  in_mode,
    input  op_t                    in_op,
    input  logic                   in_bcast,
    input  shift_t [7:0]           in_shift,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output word_t                  out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        cmd_t             cmd;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           wr_entry, head;
    logic             push, pop;
    word_t            shift_res;
    logic             out_vld_q, out_vld_d;
    word_t            out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Handshakes: a transfer happens on a cycle where both valid and ready are high.
    // in_rdy uses only the registered count, so a full FIFO never accepts even while popping.
    assign in_rdy = !rst && !flush && (occupancy != FULL);
    assign push   = in_vld && in_rdy;
    assign pop    = !flush && (occupancy != '0) && (!out_vld_q || out_rdy);

    always_comb begin
        wr_entry.cmd.data  = in_data;
        wr_entry.cmd.mode  = in_mode;
        wr_entry.cmd.op    = in_op;
        wr_entry.cmd.shift = normalise_shift(in_shift, in_bcast, in_mode);
        wr_entry.tag       = in_tag;
    end

    simd_shift_cmd_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .wdata_i     (wr_entry),
        .pop_i       (pop),
        .rdata_o     (head),
        .occupancy_o (occupancy)
    );

    simd_shifter u_shifter (
        .data   (head.cmd.data),
        .mode   (head.cmd.mode),
        .op     (head.cmd.op),
        .shift  (head.cmd.shift),
        .result (shift_res)
    );

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        if (pop) begin
            out_vld_d  = 1'b1;
            out_data_d = shift_res;
            out_tag_d  = head.tag;
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // Flush only drops the valid; the data/tag registers keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_tag  = out_tag_q;

endmodule

// File: tb/tb_simd_shift_issue.sv
// Directed bench for simd_shift_issue: hand-computed vectors, scoreboard queue drained
// by a negedge monitor, plus occupancy/ready model and output-stability checks.
`timescale 1ns/1ps
module tb_simd_shift_issue;
    import simd_shifter_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst, flush, in_vld, in_rdy, in_bcast, out_vld, out_rdy;
    word_t            in_data, out_data, cur_exp;
    mode_t            in_mode;
    op_t              in_op;
    shift_vec_t       in_shift, sv;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [2:0]       occupancy;

    logic [67:0] exp_q[$];
    logic [67:0] e;
    int          tests = 0;
    int          fails = 0;
    int          occ_m = 0;
    logic        model_ok = 1'b0;
    logic        prev_hold = 1'b0;
    logic [68:0] prev_out;

    always #5 clk = ~clk;

    simd_shift_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_op     (in_op),
        .in_bcast  (in_bcast),
        .in_shift  (in_shift),
        .in_tag    (in_tag),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input word_t d, input mode_t m, input op_t o, input logic b,
                        input shift_vec_t s, input logic [TAG_W-1:0] t, input word_t ex);
        in_data  = d;
        in_mode  = m;
        in_op    = o;
        in_bcast = b;
        in_shift = s;
        in_tag   = t;
        cur_exp  = ex;
        in_vld   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_rdy) begin
                step();
                in_vld = 1'b0;
                return;
            end
            step();
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: tag %0d never accepted, expected accept within 50 cycles", t);
        in_vld = 1'b0;
    endtask

    // Scoreboard monitor and occupancy/ready model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("occupancy_model", 64'(occupancy), 64'(occ_m));
            check("in_rdy_model", 64'(in_rdy), 64'(!rst && !flush && (occ_m != DEPTH)));
        end
        check("occupancy_bound", 64'(occupancy <= 3'(DEPTH)), 64'd1);
        if (prev_hold) check("out_stable", 64'({out_vld, out_tag, out_data} != prev_out), 64'd0);
        if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got tag %0d data 0x%0h, expected no result", out_tag, out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_tag", 64'(out_tag), 64'(e[67:64]));
                check("out_data", out_data, e[63:0]);
            end
        end
        prev_hold = out_vld && !out_rdy && !rst && !flush;
        prev_out  = {out_vld, out_tag, out_data};
        if (rst || flush) begin
            exp_q.delete();
            occ_m = 0;
        end else begin
            if (in_vld && in_rdy) exp_q.push_back({in_tag, cur_exp});
            occ_m = occ_m + ((in_vld && in_rdy) ? 1 : 0)
                          - (((occ_m != 0) && (!out_vld || out_rdy)) ? 1 : 0);
        end
        model_ok = 1'b1;
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        in_data = '0; in_mode = B8; in_op = SLL; in_bcast = 1'b0;
        in_shift = '0; in_tag = '0; cur_exp = '0; sv = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Single command with latency check
        sv = {8{6'h2A}}; sv[0] = 6'd1;
        send(64'h0102_0408_1020_4080, B8, SLL, 1'b1, sv, 4'd3, 64'h0204_0810_2040_8000);
        @(negedge clk);
        check("lat_edge_n", 64'(out_vld), 64'd0);
        @(negedge clk);
        check("lat_edge_n1", 64'(out_vld), 64'd1);
        step();

        // Back-to-back vectors covering every mode and op
        send(64'hFFFF_FFFF_FFFF_FFFF, B16, SRL, 1'b0, {8{6'h13}}, 4'd4, 64'h1FFF_1FFF_1FFF_1FFF);
        sv = {8{6'h3F}}; sv[0] = 6'd4; sv[1] = 6'h28;
        send(64'h8000_0000_7FFF_FFF0, B32, SRA, 1'b0, sv, 4'd5, 64'hFF80_0000_07FF_FFFF);
        sv = {8{6'h2A}}; sv[0] = 6'd4;
        send(64'h0123_4567_89AB_CDEF, B64, SLL, 1'b0, sv, 4'd6, 64'h1234_5678_9ABC_DEF0);
        sv = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        send(64'h8080_8080_7F7F_7F7F, B8, SRA, 1'b0, sv, 4'd7, 64'hFFFE_FCF8_0F1F_3F7F);
        sv = {8{6'h3F}}; sv[0] = 6'h11;
        send(64'h8001_4000_0001_FFFF, B16, SLL, 1'b1, sv, 4'd8, 64'h0002_8000_0002_FFFE);
        send(64'h8000_0000_0000_0000, B64, SRL, 1'b0, {8{6'h3F}}, 4'd9, 64'h0000_0000_0000_0001);
        repeat (4) step();

        // Back-pressure: fill output register and FIFO
        out_rdy = 1'b0;
        sv = '0; sv[0] = 6'd1;
        for (int i = 0; i < 5; i++) begin
            send(64'(i + 1), B64, SLL, 1'b1, sv, 4'(i), 64'(2 * (i + 1)));
        end
        @(negedge clk);
        check("bp_occupancy", 64'(occupancy), 64'd4);
        check("bp_in_rdy", 64'(in_rdy), 64'd0);
        check("bp_out_vld", 64'(out_vld), 64'd1);
        check("bp_out_tag", 64'(out_tag), 64'd0);
        step();

        // Full with simultaneous pop: no accept this cycle, accept next
        in_data = 64'd6; in_mode = B64; in_op = SLL; in_bcast = 1'b1; in_shift = sv;
        in_tag = 4'd5; cur_exp = 64'd12; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        check("full_pop_in_rdy", 64'(in_rdy), 64'd0);
        step();
        out_rdy = 1'b0;
        @(negedge clk);
        check("full_next_in_rdy", 64'(in_rdy), 64'd1);
        step();
        in_vld = 1'b0;
        @(negedge clk);
        check("full_refill_occ", 64'(occupancy), 64'd4);
        step();

        // Drain at one result per cycle
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_out_vld", 64'(out_vld), 64'd1);
        end
        @(negedge clk);
        check("drain_done_vld", 64'(out_vld), 64'd0);
        check("drain_done_occ", 64'(occupancy), 64'd0);
        step();

        // Flush with queued work and a command offered in the flush cycle
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(64'h8080_8080_8080_8080, B8, SRL, 1'b1, sv, 4'(8 + i), 64'h4040_4040_4040_4040);
        end
        @(negedge clk);
        check("pre_flush_occ", 64'(occupancy), 64'd3);
        check("pre_flush_vld", 64'(out_vld), 64'd1);
        step();
        flush = 1'b1; in_vld = 1'b1; in_tag = 4'd12; cur_exp = '0;
        @(negedge clk);
        check("flush_in_rdy", 64'(in_rdy), 64'd0);
        step();
        flush = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_out_vld", 64'(out_vld), 64'd0);
        step();
        out_rdy = 1'b1;
        sv = {8{6'h2A}}; sv[0] = 6'd1;
        send(64'h0102_0408_1020_4080, B8, SLL, 1'b1, sv, 4'd13, 64'h0204_0810_2040_8000);
        @(negedge clk);
        check("post_flush_lat_n", 64'(out_vld), 64'd0);
        @(negedge clk);
        check("post_flush_lat_n1", 64'(out_vld), 64'd1);
        step();
        repeat (2) step();

        // Reset in the middle of SRA B32 streaming
        sv = {8{6'h3F}}; sv[0] = 6'd4; sv[1] = 6'h28;
        send(64'h8000_0000_7FFF_FFF0, B32, SRA, 1'b0, sv, 4'd1, 64'hFF80_0000_07FF_FFFF);
        sv = {8{6'h00}}; sv[0] = 6'd8; sv[1] = 6'd4;
        send(64'hF000_0000_0000_0100, B32, SRA, 1'b0, sv, 4'd2, 64'hFF00_0000_0000_0001);
        send(64'hF000_0000_0000_0100, B32, SRA, 1'b0, sv, 4'd3, 64'hFF00_0000_0000_0001);
        rst = 1'b1; in_vld = 1'b1; in_tag = 4'd4; cur_exp = '0;
        @(negedge clk);
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
        step();
        @(negedge clk);
        check("mid_rst_out_vld", 64'(out_vld), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_in_rdy_hold", 64'(in_rdy), 64'd0);
        step();
        rst = 1'b0; in_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_out_vld", 64'(out_vld), 64'd0);
        end
        step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simd_shift_issue.md
Name: simd_shift_issue

Overview:
- Upstream issue stage for the combinational simd_shifter datapath.
- Accepts shift commands on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Normalises the shift vector: broadcast expansion and masking to the lane width.
- Drives the internal simd_shifter from the FIFO head and registers the result into a valid/ready output stage with tag passthrough, giving a pipelined, back-pressurable shift unit.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2
TAG_W, 4, width of opaque command tag returned with the result

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous drop of all buffered commands and of the output register
in_vld  in  1  command valid
in_rdy  out  1  command accepted when in_vld && in_rdy
in_data  in  64  operand word
in_mode  in  mode_t  lane width: B8, B16, B32, B64
in_op  in  op_t  SLL, SRL, SRA
in_bcast  in  1  1: in_shift[0] applies to every lane
in_shift  in  shift_t[7:0]  per-lane shift amounts, 6b each
in_tag  in  TAG_W  opaque tag
out_vld  out  1  result valid
out_rdy  in  1  result consumed when out_vld && out_rdy
out_data  out  64  shifted word
out_tag  out  TAG_W  tag of the command that produced out_data
occupancy  out  $clog2(DEPTH)+1  FIFO entries held; excludes the output register

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty, occupancy=0, out_vld=0, out_data=0, out_tag=0. in_rdy=0 while rst is high.
- in_rdy = !rst && !flush && (occupancy != DEPTH). Registered-count based. No same-cycle accept when full, even if a pop occurs.
- Push path:
  - On accept, shift normalisation happens before the FIFO write.
  - bcast=1 replicates in_shift[0] into all 8 entries.
  - Each entry is then ANDed with the lane mask: B8 0x07, B16 0x0F, B32 0x1F, B64 0x3F.
  - The FIFO stores data, mode, op, normalised shift and tag.
- Pop condition: occupancy!=0 && (!out_vld || out_rdy). On pop:
  - out_data <= simd_shifter(head) result.
  - out_tag <= head tag.
  - out_vld <= 1.
- If there is no pop and out_vld && out_rdy, then out_vld <= 0. out_data and out_tag hold their last values.
- Simultaneous push and pop: occupancy unchanged; pointers both advance.
- Latency: accept at edge N gives out_vld=1 after edge N+1 (2 cycles from in_vld high to result). No bypass of the FIFO.
- Throughput: 1 command per cycle sustained when out_rdy=1.
- Back-pressure: out_rdy=0 with out_vld=1 holds out_data and out_tag stable. The FIFO fills; in_rdy falls once occupancy reaches DEPTH.
- Pointers: log2(DEPTH) bits with natural wrap. Full/empty are derived from occupancy.
- flush=1 (synchronous, lower priority than rst):
  - Next cycle: occupancy=0, out_vld=0.
  - An in_vld in the flush cycle is not accepted (in_rdy=0).
  - A handshake on out_vld && out_rdy in the flush cycle still completes for the downstream consumer.
- Reset or flush mid-stream discards all in-flight commands. No partial results are emitted afterwards.
- Ordering: strict FIFO. Results emerge in accept order.
- Assertions (bench-side):
  - occupancy <= DEPTH.
  - out_data and out_tag stable while out_vld && !out_rdy.
  - No push when !in_rdy.

Decomposition:
- simd_shifter_pkg (existing shared package) holds word_t, mode_t, op_t, shift_t. Add these:
  - lane-mask function of mode_t;
  - a packed cmd_t struct {data, mode, op, shift[7:0], tag} (tag width passed via parameterised use; TAG_W-generic where possible);
  - a broadcast/normalise function.
- One sub-module: simd_shift_cmd_fifo, a generic DEPTH-entry synchronous FIFO of cmd_t with push, pop, flush and occupancy.
- simd_shifter is instanced as-is on the FIFO head.

Test Plan:
- Single command: SLL, B8, bcast=1, shift[0]=1, data=0x0102_0408_1020_4080, tag=3 -> 2 cycles later out_vld=1, out_data=0x0204_0810_2040_8000, out_tag=3.
- Masking: B16, SRL, per-lane shift 0x13 (19), data 0xFFFF_FFFF_FFFF_FFFF -> effective shift 3, every lane 0x1FFF.
- Back-pressure: out_rdy=0, push 5 commands with DEPTH=4 -> 1 in the output register, occupancy=4, in_rdy=0. Raise out_rdy -> 5 results in tag order 0..4, one per cycle.
- Full with simultaneous pop: occupancy=4, out_rdy=1, in_vld=1 -> no accept that cycle. Accept next cycle; occupancy returns to 4.
- Flush: 3 queued plus out_vld=1, assert flush with in_vld=1 -> next cycle occupancy=0, out_vld=0, new command not accepted. Subsequent command runs with 2-cycle latency.
- Reset mid-stream: rst during streaming SRA B32 traffic -> out_vld=0, out_data=0, occupancy=0 after the edge, in_rdy=0 while rst high, no stale result after release.
